cpuf_core: RTL and testbench
============================

// Module: cpuf_core
// PURPOSE
//  Parametrised multicycle accumulator CPU core; successor to the fixed 8-bit/4-bit-address datapath.
//  Generic DW/AW widths, FETCH/EXEC/HALT state machine, and one shared memory port with req/ack handshake and variable wait states.
//  Adds STA, JZ and XAB instructions plus Z/C flags. Sits between the top-level glue and a single-port RAM.
// PARAMETERS
//  DW        8   data and instruction word width; must satisfy DW >= AW+4 (otherwise elaboration error)
//  AW        4   address width; PC and operand address width
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high reset
//  mem_req    out  1   memory request; held until ack
//  mem_we     out  1   1=write (STA), 0=read
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  write data (= A during STA)
//  mem_rdata  in   DW  read data; valid in the mem_ack cycle
//  mem_ack    in   1   transfer completes on a rising edge with mem_req&mem_ack
//  halted     out  1   core is in HALT
//  pc_out     out  AW  current PC
//  acc_out    out  DW  register A
//  flag_z     out  1   zero flag
//  flag_c     out  1   carry/borrow flag
// BEHAVIOUR
//  Instruction word: opcode = word[DW-1:DW-4]; operand addr = word[AW-1:0]; other bits ignored.
//  Reset (clk edge with reset=1): state=FETCH, PC=RESET_PC, A=B=IR=0, Z=C=0, halted=0.
//   mem_req=0 combinationally while reset=1; an in-flight transfer is abandoned (RAM tolerates a dropped req).
//  FETCH: mem_req=1, we=0, addr=PC. On ack: IR<=rdata, PC<=PC+1 mod 2^AW, go EXEC. No ack: hold, outputs stable.
//  EXEC, memory ops: mem_req=1, addr=IR operand; on ack, update and go FETCH.
//  EXEC, non-memory ops: one cycle with mem_req=0, then FETCH (or HALT for HLT).
//  Zero-wait RAM (ack in same cycle): 2 cycles per instruction. Each wait state adds 1 cycle.
//  Opcodes (M = memory word at operand):
//   0000 NOP  : no-op
//   1000 LDA  : A<=M; Z
//   0100 LDB  : B<=M
//   0010 ADD  : A<=(A+M) mod 2^DW; C=carry-out; Z
//   0001 SUB  : A<=(A-M) mod 2^DW; C=borrow (A<M unsigned); Z
//   0011 STA  : M<=A (mem_we=1, mem_wdata=A)
//   0101 XAB  : swap A and B; Z from new A
//   1001 JMP  : PC<=operand
//   1011 JZ   : PC<=operand if Z=1, else no-op
//   1100 MUL  : see CONFIGURATION
//   1111 HLT  : enter HALT
//   1010 and all other codes: NOP (no memory access)
//  Flags are updated only by the ops listed with them; all other ops preserve Z and C.
//  HALT: mem_req=0, halted=1, all registers frozen; exit only by reset.
//  mem_ack while mem_req=0 is ignored. mem_req drops in the cycle after ack unless the next state requests again (FETCH->EXEC memory op keeps it high with a new address).
//  PC wraps 2^AW-1 -> 0 on increment; a JMP/JZ fetched at the last address still jumps.
// CONFIGURATION
//  CPUF_MUL_EN defined: MUL (1100) is a memory op: {B,A}<=A*M (2*DW-bit product; B=high, A=low); C=(high!=0); Z=(A==0).
//  CPUF_MUL_EN undefined: 1100 is a NOP; one EXEC cycle, no memory access, flags unchanged.
// TESTING
//  (DW=8, AW=4, RESET_PC=0)
//  1. Zero-wait RAM image {0:8E,1:2F,2:3D,3:F0,E:05,F:03}, release reset -> write 08 to addr D at cycle 6; halted=1 after 8th edge; acc_out=08, Z=0, C=0.
//  2. A=FF, ADD M=01, then JZ 0 -> A=00, Z=1, C=1; next fetch addr=0. SUB M=01 from A=00 -> A=FF, C=1, Z=0.
//  3. Repeat test 1 with 3 wait states per access -> mem_req/addr/we/wdata stable during waits; same results; halted after 8+3*7=29 edges.
//  4. JMP F with M[F]=00 (NOP) -> fetch addr sequence F then 0 (PC wrap).
//  5. Assert reset while in STA EXEC with ack withheld -> mem_req=0 in the same cycle; after the edge PC=0, A=0, halted=0, first fetch addr=0.
//  6. A=10, MUL M=20 -> with CPUF_MUL_EN: A=00, B=02, C=1, Z=1; without: A=10, no mem_req in EXEC.

Source files
------------

// File: rtl/cpuf_mem_if.sv
// Single-port memory bus between cpuf_core (master) and a RAM (slave).
// A transfer completes on a rising clock edge where mem_req and mem_ack are both high.
interface cpuf_mem_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/cpuf_core.sv
// Multicycle accumulator CPU core (FETCH/EXEC/HALT) on one shared req/ack memory port.
// Optional feature macro: CPUF_MUL_EN turns opcode 1100 into MUL ({B,A} <= A*M).
module cpuf_core #(
  parameter int            DW       = 8,
  parameter int            AW       = 4,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  cpuf_mem_if.master    mem,
  output logic          halted,
  output logic [AW-1:0] pc_out,
  output logic [DW-1:0] acc_out,
  output logic          flag_z,
  output logic          flag_c
);

  generate
    if (DW < AW + 4) begin : g_bad_width
      $error("cpuf_core: DW must be >= AW+4");
    end
  endgenerate

  localparam logic [1:0] ST_FETCH = 2'b00;
  localparam logic [1:0] ST_EXEC  = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b10;

  localparam logic [3:0] OP_LDA = 4'b1000;
  localparam logic [3:0] OP_LDB = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_STA = 4'b0011;
  localparam logic [3:0] OP_XAB = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b1001;
  localparam logic [3:0] OP_JZ  = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [AW-1:0] PC_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] DW_ZERO = {DW{1'b0}};

  logic [1:0]    state_r, state_nxt;
  logic [AW-1:0] pc_r, pc_nxt;
  logic [DW-1:0] a_r, a_nxt;
  logic [DW-1:0] b_r, b_nxt;
  logic [DW-1:0] ir_r, ir_nxt;
  logic          z_r, z_nxt;
  logic          c_r, c_nxt;

  logic [3:0]    opcode_s;
  logic [AW-1:0] operand_s;
  logic          is_mem_s;
  logic          req_s;
  logic [DW:0]   add_s;
  logic [DW:0]   sub_s;
  logic          unused_ir_s;

  assign opcode_s    = ir_r[DW-1:DW-4];
  assign operand_s   = ir_r[AW-1:0];
  assign unused_ir_s = ^ir_r;

  assign add_s = {1'b0, a_r} + {1'b0, mem.mem_rdata};
  // The extra top bit of the widened difference is the unsigned borrow (A < M).
  assign sub_s = {1'b0, a_r} - {1'b0, mem.mem_rdata};

`ifdef CPUF_MUL_EN
  logic [2*DW-1:0] prod_s;
  assign prod_s = {DW_ZERO, a_r} * {DW_ZERO, mem.mem_rdata};
`endif

  // Classify the latched instruction as memory-accessing or single-cycle.
  always_comb begin
    is_mem_s = 1'b0;
    case (opcode_s)
      OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_STA: is_mem_s = 1'b1;
`ifdef CPUF_MUL_EN
      OP_MUL:                                 is_mem_s = 1'b1;
`endif
      default:                                is_mem_s = 1'b0;
    endcase
  end

  // Bus request; reset drops it immediately, abandoning any in-flight transfer.
  always_comb begin
    req_s = 1'b0;
    if (reset) begin
      req_s = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: req_s = 1'b1;
        ST_EXEC:  req_s = is_mem_s;
        default:  req_s = 1'b0;
      endcase
    end
  end

  assign mem.mem_req   = req_s;
  assign mem.mem_we    = (state_r == ST_EXEC) && (opcode_s == OP_STA);
  assign mem.mem_addr  = (state_r == ST_FETCH) ? pc_r : operand_s;
  assign mem.mem_wdata = a_r;

  // Next-state and datapath update; every register holds unless its op fires.
  always_comb begin
    state_nxt = state_r;
    pc_nxt    = pc_r;
    a_nxt     = a_r;
    b_nxt     = b_r;
    ir_nxt    = ir_r;
    z_nxt     = z_r;
    c_nxt     = c_r;
    case (state_r)
      ST_FETCH: begin
        if (mem.mem_ack) begin
          ir_nxt    = mem.mem_rdata;
          pc_nxt    = pc_r + PC_ONE;
          state_nxt = ST_EXEC;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (is_mem_s) begin
          if (mem.mem_ack) begin
            state_nxt = ST_FETCH;
            case (opcode_s)
              OP_LDA: begin
                a_nxt = mem.mem_rdata;
                z_nxt = (mem.mem_rdata == DW_ZERO);
              end
              OP_LDB: b_nxt = mem.mem_rdata;
              OP_ADD: begin
                a_nxt = add_s[DW-1:0];
                c_nxt = add_s[DW];
                z_nxt = (add_s[DW-1:0] == DW_ZERO);
              end
              OP_SUB: begin
                a_nxt = sub_s[DW-1:0];
                c_nxt = sub_s[DW];
                z_nxt = (sub_s[DW-1:0] == DW_ZERO);
              end
`ifdef CPUF_MUL_EN
              OP_MUL: begin
                a_nxt = prod_s[DW-1:0];
                b_nxt = prod_s[2*DW-1:DW];
                c_nxt = (prod_s[2*DW-1:DW] != DW_ZERO);
                z_nxt = (prod_s[DW-1:0] == DW_ZERO);
              end
`endif
              default: state_nxt = ST_FETCH;
            endcase
          end else begin
            state_nxt = ST_EXEC;
          end
        end else begin
          state_nxt = ST_FETCH;
          case (opcode_s)
            OP_XAB: begin
              a_nxt = b_r;
              b_nxt = a_r;
              z_nxt = (b_r == DW_ZERO);
            end
            OP_JMP: pc_nxt = operand_s;
            OP_JZ: begin
              if (z_r) begin
                pc_nxt = operand_s;
              end else begin
                pc_nxt = pc_r;
              end
            end
            OP_HLT:  state_nxt = ST_HALT;
            default: state_nxt = ST_FETCH;
          endcase
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  // Architectural state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
      a_r     <= DW_ZERO;
      b_r     <= DW_ZERO;
      ir_r    <= DW_ZERO;
      z_r     <= 1'b0;
      c_r     <= 1'b0;
    end else begin
      state_r <= state_nxt;
      pc_r    <= pc_nxt;
      a_r     <= a_nxt;
      b_r     <= b_nxt;
      ir_r    <= ir_nxt;
      z_r     <= z_nxt;
      c_r     <= c_nxt;
    end
  end

  assign halted  = (state_r == ST_HALT);
  assign pc_out  = pc_r;
  assign acc_out = a_r;
  assign flag_z  = z_r;
  assign flag_c  = c_r;

endmodule

// File: tb/tb_cpuf_core.sv
// Self-checking bench for cpuf_core (DW=8, AW=4): program table plus a reset-during-STA sequence.
// Bus transfers are checked against a scoreboard filled by an instruction-level reference model.
module tb_cpuf_core;

  typedef struct {
    logic [15:0][7:0] img;
    int               waits;
    logic [7:0]       acc;
    logic             z;
    logic             c;
    int               cycles;
    int               wr_cycle;
  } vec_t;

  typedef struct {
    logic [3:0] addr;
    logic       we;
    logic [7:0] wdata;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic halted;
  logic [3:0] pc_out;
  logic [7:0] acc_out;
  logic flag_z, flag_c;

  cpuf_mem_if #(.DW(8), .AW(4)) mif ();

  cpuf_core #(.DW(8), .AW(4), .RESET_PC(4'h0)) dut (
    .clk     (clk),
    .reset   (reset),
    .mem     (mif),
    .halted  (halted),
    .pc_out  (pc_out),
    .acc_out (acc_out),
    .flag_z  (flag_z),
    .flag_c  (flag_c)
  );

  always #5 clk = ~clk;

  // RAM model with programmable wait states and an ack-withhold control
  logic [7:0]       ram [16];
  logic [15:0][7:0] load_img;
  logic             load_en = 1'b0;
  logic             ack_block = 1'b0;
  int               waits_cfg = 0;
  int               cnt = 0;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 16; i++) ram[i] <= load_img[i];
      cnt <= 0;
    end else if (mif.mem_req && mif.mem_ack) begin
      if (mif.mem_we) ram[mif.mem_addr] <= mif.mem_wdata;
      cnt <= 0;
    end else if (mif.mem_req) begin
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  assign mif.mem_ack   = !ack_block && (cnt >= waits_cfg);
  assign mif.mem_rdata = ram[mif.mem_addr];

  int   n_cmp = 0;
  int   n_bad = 0;
  sb_t  sbq[$];
  vec_t vecs[8];
  int   cyc;
  int   last_wr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic put(input int k, input int a, input logic [7:0] d);
    vecs[k].img[a] = d;
  endtask

  // Instruction-level reference: pushes every expected bus transfer, returns final PC
  task automatic build_expect(input logic [15:0][7:0] img, output logic [3:0] pc_f);
    logic [7:0]  m [16];
    logic [7:0]  a, b, ir, t8;
    logic [8:0]  t;
    logic [15:0] p;
    logic        z, c, stop;
    logic [3:0]  pc, opc, oa;
    for (int i = 0; i < 16; i++) m[i] = img[i];
    a = 8'h00; b = 8'h00; z = 1'b0; c = 1'b0; pc = 4'h0; stop = 1'b0;
    sbq.delete();
    for (int n = 0; n < 64 && !stop; n++) begin
      sbq.push_back('{pc, 1'b0, 8'h00});
      ir = m[pc];
      pc = pc + 4'd1;
      opc = ir[7:4];
      oa = ir[3:0];
      case (opc)
        4'h8: begin sbq.push_back('{oa, 1'b0, 8'h00}); a = m[oa]; z = (a == 8'h00); end
        4'h4: begin sbq.push_back('{oa, 1'b0, 8'h00}); b = m[oa]; end
        4'h2: begin
          sbq.push_back('{oa, 1'b0, 8'h00});
          t = {1'b0, a} + {1'b0, m[oa]}; a = t[7:0]; c = t[8]; z = (a == 8'h00);
        end
        4'h1: begin
          sbq.push_back('{oa, 1'b0, 8'h00});
          c = (a < m[oa]); a = a - m[oa]; z = (a == 8'h00);
        end
        4'h3: begin sbq.push_back('{oa, 1'b1, a}); m[oa] = a; end
        4'h5: begin t8 = a; a = b; b = t8; z = (a == 8'h00); end
        4'h9: pc = oa;
        4'hB: if (z) pc = oa;
`ifdef CPUF_MUL_EN
        4'hC: begin
          sbq.push_back('{oa, 1'b0, 8'h00});
          p = {8'h00, a} * {8'h00, m[oa]};
          a = p[7:0]; b = p[15:8]; c = (b != 8'h00); z = (a == 8'h00);
        end
`endif
        4'hF: stop = 1'b1;
        default: ;
      endcase
    end
    pc_f = pc;
  endtask

  task automatic load_and_reset(input logic [15:0][7:0] img, input int w);
    @(negedge clk);
    reset = 1'b1;
    load_img = img;
    waits_cfg = w;
    ack_block = 1'b0;
    load_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input int k);
    logic [3:0] exp_pc;
    logic       done, pend;
    sb_t        e;
    build_expect(vecs[k].img, exp_pc);
    load_and_reset(vecs[k].img, vecs[k].waits);
    reset = 1'b0;
    cyc = 0; last_wr = 0; done = 1'b0; pend = 1'b0;
    while (!done && cyc < 400) begin
      #1;
      if (pend) chk($sformatf("v%0d_req_hold", k), 32'(mif.mem_req), 32'd1);
      if (mif.mem_req) begin
        if (sbq.size() == 0) begin
          chk($sformatf("v%0d_sb_extra", k), 32'(mif.mem_addr), 32'hFFFF);
        end else begin
          e = sbq[0];
          chk($sformatf("v%0d_bus", k),
              32'({mif.mem_addr, mif.mem_we, mif.mem_we ? mif.mem_wdata : 8'h00}),
              32'({e.addr, e.we, e.we ? e.wdata : 8'h00}));
          if (mif.mem_ack) begin
            void'(sbq.pop_front());
            if (mif.mem_we) last_wr = cyc + 1;
          end
        end
      end
      pend = mif.mem_req && !mif.mem_ack;
      @(posedge clk);
      cyc++;
      #1;
      if (halted) done = 1'b1;
      else @(negedge clk);
    end
    chk($sformatf("v%0d_halt_reached", k), 32'(done), 32'd1);
    chk($sformatf("v%0d_cycles", k), 32'(cyc), 32'(vecs[k].cycles));
    chk($sformatf("v%0d_acc", k), 32'(acc_out), 32'(vecs[k].acc));
    chk($sformatf("v%0d_z", k), 32'(flag_z), 32'(vecs[k].z));
    chk($sformatf("v%0d_c", k), 32'(flag_c), 32'(vecs[k].c));
    chk($sformatf("v%0d_sb_left", k), 32'(sbq.size()), 32'd0);
    if (vecs[k].wr_cycle != 0) chk($sformatf("v%0d_wr_cycle", k), 32'(last_wr), 32'(vecs[k].wr_cycle));
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("v%0d_frozen_pc", k), 32'(pc_out), 32'(exp_pc));
    chk($sformatf("v%0d_frozen_req", k), 32'({halted, mif.mem_req}), 32'b10);
  endtask

  initial begin
    logic found;
    for (int k = 0; k < 8; k++) vecs[k].img = '0;
    // add/store/halt program, zero and three wait states
    put(0, 0, 8'h8E); put(0, 1, 8'h2F); put(0, 2, 8'h3D); put(0, 3, 8'hF0);
    put(0, 14, 8'h05); put(0, 15, 8'h03);
    vecs[1].img = vecs[0].img;
    vecs[0].waits = 0; vecs[0].acc = 8'h08; vecs[0].z = 1'b0; vecs[0].c = 1'b0; vecs[0].cycles = 8;  vecs[0].wr_cycle = 6;
    vecs[1].waits = 3; vecs[1].acc = 8'h08; vecs[1].z = 1'b0; vecs[1].c = 1'b0; vecs[1].cycles = 29; vecs[1].wr_cycle = 24;
    // FF+01 -> 00 (Z,C), JZ taken to 5, SUB 00-01 -> FF
    put(2, 0, 8'h8E); put(2, 1, 8'h2F); put(2, 2, 8'hB5); put(2, 5, 8'h1F); put(2, 6, 8'hF0);
    put(2, 14, 8'hFF); put(2, 15, 8'h01);
    vecs[2].waits = 0; vecs[2].acc = 8'hFF; vecs[2].z = 1'b0; vecs[2].c = 1'b1; vecs[2].cycles = 10; vecs[2].wr_cycle = 0;
    // JZ not taken
    put(3, 0, 8'h8F); put(3, 1, 8'hB4); put(3, 2, 8'hF0); put(3, 4, 8'h8F); put(3, 15, 8'h01);
    vecs[3].waits = 0; vecs[3].acc = 8'h01; vecs[3].z = 1'b0; vecs[3].c = 1'b0; vecs[3].cycles = 6; vecs[3].wr_cycle = 0;
    // self-modifying: STA HLT into 0, JMP F, NOP at F wraps PC to 0
    put(4, 0, 8'h8C); put(4, 1, 8'h30); put(4, 2, 8'h9F); put(4, 12, 8'hF0); put(4, 15, 8'h00);
    vecs[4].waits = 2; vecs[4].acc = 8'hF0; vecs[4].z = 1'b0; vecs[4].c = 1'b0; vecs[4].cycles = 24; vecs[4].wr_cycle = 12;
    // MUL 10*20, then MUL followed by XAB
    put(5, 0, 8'h8E); put(5, 1, 8'hCF); put(5, 2, 8'hF0); put(5, 14, 8'h10); put(5, 15, 8'h20);
    put(6, 0, 8'h8E); put(6, 1, 8'hCF); put(6, 2, 8'h50); put(6, 3, 8'hF0); put(6, 14, 8'h10); put(6, 15, 8'h20);
`ifdef CPUF_MUL_EN
    vecs[5].acc = 8'h00; vecs[5].z = 1'b1; vecs[5].c = 1'b1;
    vecs[6].acc = 8'h02; vecs[6].z = 1'b0; vecs[6].c = 1'b1;
`else
    vecs[5].acc = 8'h10; vecs[5].z = 1'b0; vecs[5].c = 1'b0;
    vecs[6].acc = 8'h00; vecs[6].z = 1'b1; vecs[6].c = 1'b0;
`endif
    vecs[5].waits = 0; vecs[5].cycles = 6; vecs[5].wr_cycle = 0;
    vecs[6].waits = 0; vecs[6].cycles = 8; vecs[6].wr_cycle = 0;
    // LDB, LDA, SUB borrow, XAB, opcode 1010 as NOP, one wait state
    put(7, 0, 8'h4E); put(7, 1, 8'h8F); put(7, 2, 8'h1E); put(7, 3, 8'h50); put(7, 4, 8'hA0); put(7, 5, 8'hF0);
    put(7, 14, 8'h05); put(7, 15, 8'h03);
    vecs[7].waits = 1; vecs[7].acc = 8'h05; vecs[7].z = 1'b0; vecs[7].c = 1'b1; vecs[7].cycles = 21; vecs[7].wr_cycle = 0;

    for (int k = 0; k < 8; k++) run_vec(k);

    // reset state after a halted run with non-zero A and C
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_req_comb", 32'(mif.mem_req), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_state", 32'({pc_out, acc_out, flag_z, flag_c, halted}), 32'd0);

    // reset while STA EXEC waits for a withheld ack
    load_and_reset(vecs[0].img, 0);
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      #1;
      if (mif.mem_req && mif.mem_we) begin
        found = 1'b1;
        ack_block = 1'b1;
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk("sta_reached", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    chk("sta_stalled", 32'({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata}), 32'({1'b1, 1'b1, 4'hD, 8'h08}));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("sta_reset_req", 32'(mif.mem_req), 32'd0);
    @(posedge clk);
    #1;
    chk("sta_reset_state", 32'({pc_out, acc_out, halted}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ack_block = 1'b0;
    #1;
    chk("sta_refetch", 32'({mif.mem_req, mif.mem_we, mif.mem_addr}), 32'({1'b1, 1'b0, 4'h0}));
    chk("sta_no_write", 32'(ram[13]), 32'h00);
    reset = 1'b1;
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
